// File: rtl/audio_i2s_rx_if.sv
// rtl/audio_i2s_rx_if.sv - captured-sample stream between the I2S receiver and its consumer
interface audio_i2s_rx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] o_data;
  logic              o_chan;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, o_chan, o_valid, input i_ready);
  modport slave  (input o_data, o_chan, o_valid, output i_ready);
endinterface

// File: rtl/audio_i2s_rx.sv
// rtl/audio_i2s_rx.sv - oversampled I2S / left-justified ADC capture with sample FIFO
module audio_i2s_rx #(
  parameter int DATA_W     = 16,
  parameter bit MODE_I2S   = 1'b1,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_bclk,
  input  logic           i_lrck,
  input  logic           i_adcdat,
  input  logic           i_en,
  audio_i2s_rx_if.master smp,
  output logic           o_overrun,
  input  logic           i_clr_overrun,
  output logic [LW-1:0]  o_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_EDGE, S_SKIP, S_SHIFT, S_HOLD} state_t;

  // [0],[1] = synchroniser stages, [2] = history flop
  logic [2:0]        bclk_q, lrck_q, dat_q;
  logic              bit_rise, lr_s, dat_s, lr_edge;
  logic              lr_last_q, lr_seen_q;
  logic              unused_hist;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_cur;
  logic [DATA_W-1:0] shift_q, shift_d, shift_in;
  logic              chan_q, chan_d, push_q, push_d;
  logic              start_slot, take_bit;

  assign bit_rise    = bclk_q[1] & ~bclk_q[2];
  assign lr_s        = lrck_q[1];
  assign dat_s       = dat_q[1];
  // lr_seen_q stops the first rise after reset from faking an edge mid-slot
  assign lr_edge     = bit_rise & lr_seen_q & (lr_s != lr_last_q);
  assign unused_hist = ^{lrck_q[2], dat_q[2]};

  if (DATA_W > 1) begin : g_shift
    assign shift_in = {shift_q[DATA_W-2:0], dat_s};
  end else begin : g_shift1
    assign shift_in = dat_s;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bclk_q    <= '0;
      lrck_q    <= '0;
      dat_q     <= '0;
      lr_last_q <= 1'b0;
      lr_seen_q <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[1:0], i_bclk};
      lrck_q <= {lrck_q[1:0], i_lrck};
      dat_q  <= {dat_q[1:0], i_adcdat};
      if (bit_rise) begin
        lr_last_q <= lr_s;
        lr_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      chan_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      chan_q  <= chan_d;
      push_q  <= push_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    chan_d     = chan_q;
    push_d     = 1'b0;
    start_slot = 1'b0;
    take_bit   = 1'b0;
    cnt_cur    = cnt_q;

    if (!i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:               state_d = S_WAIT_EDGE;
        S_WAIT_EDGE, S_HOLD:  start_slot = lr_edge;
        S_SKIP, S_SHIFT: begin
          start_slot = lr_edge;
          take_bit   = bit_rise & ~lr_edge;
        end
        default:              state_d = S_IDLE;
      endcase
    end

    // Left-justified slots carry the MSB on the edge rise itself
    if (start_slot) begin
      chan_d  = MODE_I2S ? lr_s : ~lr_s;
      cnt_d   = '0;
      cnt_cur = '0;
      if (MODE_I2S) state_d = S_SKIP;
      else          take_bit = 1'b1;
    end

    if (take_bit) begin
      shift_d = shift_in;
      if (cnt_cur == CW'(DATA_W - 1)) begin
        push_d  = 1'b1;
        state_d = S_HOLD;
      end else begin
        cnt_d   = cnt_cur + 1'b1;
        state_d = S_SHIFT;
      end
    end
  end

  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic            ovr_q;
  logic            empty, full, pop, wr, drop;
  logic [DATA_W:0] head;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign pop   = ~empty & smp.i_ready;
  // A pop in the push cycle frees the slot, so a full FIFO still accepts
  assign wr    = push_q & (~full | pop);
  assign drop  = push_q & full & ~pop;
  assign head  = mem_q[rptr_q];

  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wptr_q] <= {chan_q, shift_q};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LW'(wr) - LW'(pop);
      ovr_q   <= (ovr_q & ~i_clr_overrun) | drop;
    end
  end

  assign smp.o_valid = ~empty;
  assign smp.o_data  = empty ? '0 : head[DATA_W-1:0];
  assign smp.o_chan  = empty ? 1'b0 : head[DATA_W];
  assign o_overrun   = ovr_q;
  assign o_level     = level_q;
endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb/tb_audio_i2s_rx.sv - randomized bench for audio_i2s_rx against a slot-level reference model
module tb_audio_i2s_rx;
  localparam int DW_A  = 16;
  localparam int DW_B  = 24;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, bclk, lrck, adcdat, en, rdy, clr;
  logic       ovr_a, ovr_b;
  logic [2:0] lvl_a, lvl_b;

  audio_i2s_rx_if #(.DATA_W(DW_A)) ia ();
  audio_i2s_rx_if #(.DATA_W(DW_B)) ib ();
  assign ia.i_ready = rdy;
  assign ib.i_ready = 1'b1;

  audio_i2s_rx #(.DATA_W(DW_A), .MODE_I2S(1'b1), .FIFO_DEPTH(DEPTH)) u_i2s (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk(bclk), .i_lrck(lrck), .i_adcdat(adcdat),
    .i_en(en), .smp(ia), .o_overrun(ovr_a), .i_clr_overrun(clr), .o_level(lvl_a)
  );

  audio_i2s_rx #(.DATA_W(DW_B), .MODE_I2S(1'b0), .FIFO_DEPTH(DEPTH)) u_lj (
    .i_clk(clk), .i_rst_n(rst_n), .i_bclk(bclk), .i_lrck(lrck), .i_adcdat(adcdat),
    .i_en(en), .smp(ib), .o_overrun(ovr_b), .i_clr_overrun(1'b0), .o_level(lvl_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected samples as {chan, 32-bit right-aligned data}
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];
  logic [32:0] ea, eb;
  bit          fresh, probe_on, rand_rdy;
  logic        prev_lr;
  int          pc, probe_mode;

  always @(negedge clk) begin
    if (rst_n && ia.o_valid && ia.i_ready) begin
      if (exp_a.size() == 0) chk("i2s_unexpected_sample", 1, 0);
      else begin
        ea = exp_a.pop_front();
        chk("i2s_sample", {ia.o_chan, 16'h0, ia.o_data}, ea);
      end
    end
    if (rst_n && ib.o_valid && ib.i_ready) begin
      if (exp_b.size() == 0) chk("lj_unexpected_sample", 1, 0);
      else begin
        eb = exp_b.pop_front();
        chk("lj_sample", {ib.o_chan, 8'h0, ib.o_data}, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (probe_on) begin
      pc++;
      if (pc == 3) begin
        case (probe_mode)
          0: begin
            chk("lat_edge3_valid", ia.o_valid, 0);
            chk("lat_edge3_level", lvl_a, 0);
          end
          1: clr = 1'b1;
          default: rdy = 1'b1;
        endcase
      end else if (pc == 4) begin
        case (probe_mode)
          0: begin
            chk("lat_edge4_valid", ia.o_valid, 1);
            chk("lat_edge4_level", lvl_a, 1);
          end
          1: begin
            clr = 1'b0;
            chk("clr_with_drop_overrun", ovr_a, 1);
            chk("clr_with_drop_level", lvl_a, 4);
          end
          default: begin
            rdy = 1'b0;
            chk("full_pop_level", lvl_a, 4);
            chk("full_pop_overrun", ovr_a, 0);
          end
        endcase
        probe_on = 1'b0;
      end
    end
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic lr, input logic d, input int k,
                          input int probe_idx, input int rst_idx, input int en_idx);
    bclk   = 1'b0;
    lrck   = lr;
    adcdat = d;
    if (k == en_idx) en = 1'b1;
    if (k == rst_idx) begin
      rst_n = 1'b0;
      tick();
      chk("rst_mid_valid", ia.o_valid, 0);
      chk("rst_mid_level", lvl_a, 0);
      chk("rst_mid_overrun", ovr_a, 0);
      chk("rst_mid_data", ia.o_data, 0);
      chk("rst_mid_chan", ia.o_chan, 0);
      rst_n = 1'b1;
    end
    tick();
    tick();
    bclk = 1'b1;
    if (k == probe_idx) begin
      probe_on = 1'b1;
      pc       = 0;
    end
    tick();
    tick();
  endtask

  // One LRCK half-frame of n bits, bit k = bits[31-k] sampled on the k-th rise.
  // I2S keeps rises 1..16 when the slot reaches rise 16; LJ keeps rises 0..23.
  task automatic send_slot(input logic lr, input int n, input logic [31:0] bits,
                           input int probe_idx = -1, input int rst_idx = -1,
                           input int en_idx = -1);
    bit armed;
    armed = en && fresh && (lr != prev_lr) && (rst_idx < 0);
    if (armed && n >= DW_A + 1) exp_a.push_back({lr, 16'h0, bits[30:15]});
    if (armed && n >= DW_B)     exp_b.push_back({~lr, 8'h0, bits[31:8]});
    for (int k = 0; k < n; k++) send_bit(lr, bits[31-k], k, probe_idx, rst_idx, en_idx);
    if (rst_idx >= 0) begin
      exp_a.delete();
      exp_b.delete();
    end
    fresh   = 1'b1;
    prev_lr = lr;
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    rdy      = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 64 && (ia.o_valid || ib.o_valid); i++) tick();
    chk("drain_i2s_valid", ia.o_valid, 0);
    chk("drain_i2s_pending", exp_a.size(), 0);
    chk("drain_lj_pending", exp_b.size(), 0);
  endtask

  int lens[8] = '{32, 32, 32, 24, 20, 8, 17, 16};

  initial begin
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b0; adcdat = 1'b0;
    en = 1'b0; rdy = 1'b0; clr = 1'b0;
    fresh = 1'b0; prev_lr = 1'b0; probe_on = 1'b0; rand_rdy = 1'b0;
    pc = 0; probe_mode = 0;
    repeat (3) tick();
    chk("rst_valid", ia.o_valid, 0);
    chk("rst_level", lvl_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_data", ia.o_data, 0);
    chk("rst_chan", ia.o_chan, 0);
    chk("rst_lj_valid", ib.o_valid, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    rdy   = 1'b1;
    tick();
    tick();
    send_slot(1'b1, 32, $urandom);
    probe_mode = 0;
    send_slot(1'b0, 32, {1'b0, 16'hA55A, 15'($urandom)}, 16);
    send_slot(1'b1, 32, {1'b1, 16'h1234, 15'h5});
    send_slot(1'b0, 32, $urandom);
    send_slot(1'b1, 32, {24'hC00001, 8'($urandom)});
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send_slot(~prev_lr, lens[$urandom_range(0, 7)], $urandom);
    send_slot(~prev_lr, 8, $urandom);
    send_slot(~prev_lr, 32, $urandom);
    drain();

    rdy = 1'b0;
    for (int v = 1; v <= 5; v++) send_slot(~prev_lr, 32, {1'b0, 16'(v), 15'h0});
    repeat (4) tick();
    chk("overrun_level", lvl_a, 4);
    chk("overrun_flag", ovr_a, 1);
    void'(exp_a.pop_back());
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("overrun_cleared", ovr_a, 0);
    probe_mode = 1;
    send_slot(~prev_lr, 32, {1'b0, 16'd6, 15'h0}, 16);
    void'(exp_a.pop_back());
    drain();

    clr = 1'b1;
    tick();
    clr = 1'b0;
    rdy = 1'b0;
    for (int v = 7; v <= 10; v++) send_slot(~prev_lr, 32, {1'b0, 16'(v), 15'h0});
    probe_mode = 2;
    send_slot(~prev_lr, 32, {1'b0, 16'd11, 15'h0}, 16);
    drain();

    en = 1'b0;
    tick();
    send_slot(~prev_lr, 32, $urandom);
    send_slot(~prev_lr, 32, $urandom, -1, -1, 10);
    send_slot(~prev_lr, 32, $urandom);
    drain();

    rdy = 1'b0;
    send_slot(~prev_lr, 32, $urandom);
    send_slot(~prev_lr, 32, $urandom, -1, 10);
    send_slot(~prev_lr, 32, $urandom);
    send_slot(~prev_lr, 32, $urandom);
    drain();

    chk("lj_overrun", ovr_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/audio_i2s_rx.md
# audio_i2s_rx

Parametrised serial-audio capture block for the DE2-115 WM8731 path. It sits between the codec ADC pins (`AUD_BCLK`, `AUD_ADCLRCK`, `AUD_ADCDAT`, with the codec as bus master) and the recorder logic in `Main`. It oversamples the codec clocks in the `i_clk` domain and deserialises one sample per LRCK half-frame. Captured samples are queued in a small FIFO and delivered over a valid/ready stream with overrun reporting.

## Interface
- `DATA_W`, 16: captured sample width, 1..32; slot bits beyond `DATA_W` are ignored.
- `MODE_I2S`, 1: 1 = Philips I2S (MSB one BCLK after the LRCK edge, LRCK low = left); 0 = left-justified (MSB on the first BCLK after the LRCK edge, LRCK high = left).
- `FIFO_DEPTH`, 4: sample FIFO depth, power of 2, ≥2.
- `LW`, derived as $clog2(`FIFO_DEPTH`)+1: width of the level output.

Ports:
- `i_clk`, in, 1: system clock (`clk_12m`); the only clock.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_bclk`, in, 1: codec bit clock, treated as data.
- `i_lrck`, in, 1: codec ADC LR clock.
- `i_adcdat`, in, 1: codec ADC serial data.
- `i_en`, in, 1: capture enable.
- `o_data`, out, `DATA_W`: sample at the FIFO head, MSB-first order preserved.
- `o_chan`, out, 1: channel of the head sample; 0 = left, 1 = right.
- `o_valid`, out, 1: FIFO not empty.
- `i_ready`, in, 1: consumer accepts the head sample.
- `o_overrun`, out, 1: sticky flag, set when a sample is dropped because the FIFO is full.
- `i_clr_overrun`, in, 1: clears `o_overrun`.
- `o_level`, out, `LW`: current FIFO occupancy.

## Operation
- **Input synchronisation:** `i_bclk`, `i_lrck` and `i_adcdat` each pass through an identical 2-flop synchroniser followed by one history flop.
  - BCLK rise = sync stage 2 is 1 and the history flop is 0.
  - All decisions are made only on BCLK rises.
  - LRCK value and data bit are taken from the stage-2 flops in the same cycle.
- **LRCK edge:** a BCLK rise where synced LRCK differs from the LRCK latched at the previous BCLK rise. The channel is latched on this edge according to the `MODE_I2S` polarity.
- **FSM states:**
  - IDLE: when `i_en`=1, go to WAIT_EDGE.
  - WAIT_EDGE: on an LRCK edge, go to SKIP if `MODE_I2S`, else to SHIFT, capturing this rise as bit 0.
  - SKIP: on the next BCLK rise, go to SHIFT.
  - SHIFT: shift one bit per BCLK rise, counting 0..`DATA_W`-1. After bit `DATA_W`-1, issue a push strobe and go to HOLD.
  - HOLD: ignore bits until the next LRCK edge, then re-enter SHIFT/SKIP exactly as from WAIT_EDGE.
- **Short slot:** an LRCK edge while in SKIP or SHIFT discards the partial sample (no push) and restarts on the new slot.
- **Disable:** `i_en`=0 in any state returns the FSM to IDLE next cycle and drops any partial sample. FIFO contents are kept.
- **Mid-slot enable:** capture always waits for the next LRCK edge. A partial slot is never captured.
- **FIFO push:** writes {`o_chan`, data} when not full.
  - Push while full with no pop: the new sample is dropped and `o_overrun` is set.
  - Push and pop in the same cycle while full: both occur, no overrun.
- **FIFO pop:** happens when `o_valid` and `i_ready` are both 1. `i_ready` while empty has no effect.
- **Overrun flag:** `i_clr_overrun` clears `o_overrun`. A clear and a new overrun in the same cycle leave the flag set.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH`. `o_level` ranges 0..`FIFO_DEPTH`.

## Timing
- **Reset:** FSM in IDLE, FIFO empty. `o_valid`=0, `o_level`=0, `o_overrun`=0, `o_data`=0, `o_chan`=0. Synchroniser and shift registers are 0.
- **Reset mid-slot:** any partial sample is lost. After reset, capture resumes only at an LRCK edge with `i_en`=1.
- **Input clock constraint:** `i_bclk` high and low phases must each be ≥2 `i_clk` cycles, i.e. f_bclk ≤ f_clk/4. `i_lrck` and `i_adcdat` must be stable across each BCLK rise.
- **Capture latency:** number `i_clk` edges starting with edge 1 = the edge that first samples the last-data-bit `i_bclk`=1.
  - The shift/push strobe occurs at edge 3.
  - The FIFO write occurs at edge 4.
  - With an empty FIFO, `o_valid`=1 and `o_level`=1 after edge 4.
- **Pop timing:** the pop takes effect on the same edge it is accepted. The next head sample, or `o_valid`=0, is visible after that edge.
- **Output behaviour:** `o_data` and `o_chan` are stable while `o_valid`=1 and `i_ready`=0.

## Test plan
- **I2S basic** (`DATA_W`=16, `MODE_I2S`=1, 32-bit slots, f_bclk = f_clk/4): send left 0xA55A, right 0x1234 with `i_ready`=1 → two samples, (chan 0, 0xA55A) then (chan 1, 0x1234). `o_valid` rises on edge 4 after the last bit.
- **Left-justified, DATA_W=24** (`MODE_I2S`=0): send LRCK-high slot 0xC00001 → (chan 0, 0xC00001). Trailing slot bits are ignored and no extra sample appears.
- **Overrun** (`FIFO_DEPTH`=4, `i_ready`=0): 5 slots 1..5 → `o_level`=4 and `o_overrun`=1. Popping yields 1,2,3,4 and sample 5 is absent. Pulse `i_clr_overrun` → flag 0. Clear coinciding with another dropped sample → flag stays 1.
- **Full with simultaneous pop:** FIFO full, `i_ready`=1 on the push cycle → `o_level` stays 4, `o_overrun` stays 0, data order is preserved.
- **Enable, short slot, reset:**
  - Raise `i_en` mid-slot → that slot is not captured; the first sample is the next full slot.
  - An 8-bit slot with `DATA_W`=16 → no push.
  - `i_rst_n`=0 during SHIFT → all outputs 0 on the next edge, and no sample is produced from that slot.
